seg_scan_ctrl: RTL

Time-multiplexed scan controller for the board's shared 7-segment display. It sequences up to 8 digit positions over the single `seg` bus. A shadow snapshot is taken at each frame start so that counter updates never tear a frame. A blanking gap is inserted between digits to prevent ghosting. The block sits between the time-keeping counters (BCD digit sources) and the display pins, replacing ad-hoc clock-level muxing with a clean, parameterised scheduler.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_scan_ctrl_decode.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and segment constants for the 7-segment scan path.
// Holds the scan FSM state enum, segment patterns and a small max helper.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BLANK,
    SHOW
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ERR   = 8'h79;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// seg7_decode: combinational BCD to 7-segment decoder, non-BCD shows "E".
// Ports: val (4b BCD), dp (decimal point) -> seg (bit7 dp, bits6..0 g..a).
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] val,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] lo;

  always_comb begin
    lo = SEG_ERR[6:0];
    unique case (val)
      4'd0:    lo = SEG_0;
      4'd1:    lo = SEG_1;
      4'd2:    lo = SEG_2;
      4'd3:    lo = SEG_3;
      4'd4:    lo = SEG_4;
      4'd5:    lo = SEG_5;
      4'd6:    lo = SEG_6;
      4'd7:    lo = SEG_7;
      4'd8:    lo = SEG_8;
      4'd9:    lo = SEG_9;
      default: lo = SEG_ERR[6:0];
    endcase
  end

  assign seg = {dp, lo};

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: frame-snapshotted, blank-gapped scanner for a shared 7-seg bus.
// Ports: clk, rst, en, digits/dp/digit_en in; sel, seg, frame_done registered out.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int DWELL_CYCLES = 50,
  parameter int BLANK_CYCLES = 2,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [2:0]              sel,
  output logic [7:0]              seg,
  output logic                    frame_done
);

  localparam int CW =
    $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              sel_q, sel_d;
  logic [7:0]              seg_q, seg_d;
  logic                    fd_q, fd_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
  logic [NUM_DIGITS-1:0]   msk_q, msk_d;

  logic [2:0] first_idx;
  logic       first_any;
  logic [2:0] next_idx;
  logic       next_any;
  logic [3:0] cur_val;
  logic       cur_dp;
  logic       hi_zero;
  logic       lz;
  logic [7:0] dec_seg;
  logic [7:0] show_seg;

  // Lowest enabled index of the live mask, used on LOAD.
  always_comb begin
    first_idx = '0;
    first_any = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_en[i]) begin
        first_idx = 3'(i);
        first_any = 1'b1;
      end
    end
  end

  // Next enabled shadow index strictly above sel.
  always_comb begin
    next_idx = '0;
    next_any = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (msk_q[i] && (i > int'(sel_q))) begin
        next_idx = 3'(i);
        next_any = 1'b1;
      end
    end
  end

  always_comb begin
    cur_val = '0;
    cur_dp  = 1'b0;
    hi_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == int'(sel_q)) begin
        cur_val = dig_q[4*i +: 4];
        cur_dp  = dpm_q[i];
      end
      if ((i > int'(sel_q)) && msk_q[i] &&
          (dig_q[4*i +: 4] != 4'd0)) begin
        hi_zero = 1'b0;
      end
    end
  end

  seg7_decode u_dec (
    .val (cur_val),
    .dp  (cur_dp),
    .seg (dec_seg)
  );

  // Zero with only zero enabled digits above it goes dark; dp survives.
  assign lz = (LZ_SUPPRESS != 0) && (sel_q != 3'd0) &&
              (cur_val == 4'd0) && hi_zero;

  assign show_seg = {dec_seg[7], lz ? 7'b0 : dec_seg[6:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    seg_d   = seg_q;
    fd_d    = 1'b0;
    dig_d   = dig_q;
    dpm_d   = dpm_q;
    msk_d   = msk_q;
    if (!en) begin
      state_d = IDLE;
      sel_d   = '0;
      seg_d   = SEG_BLANK;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = LOAD;
          seg_d   = SEG_BLANK;
        end
        LOAD: begin
          dig_d = digits;
          dpm_d = dp;
          msk_d = digit_en;
          seg_d = SEG_BLANK;
          if (first_any) begin
            state_d = BLANK;
            sel_d   = first_idx;
            cnt_d   = BLANK_LD;
          end
        end
        BLANK: begin
          seg_d = SEG_BLANK;
          if (cnt_q == '0) begin
            state_d = SHOW;
            cnt_d   = DWELL_LD;
            seg_d   = show_seg;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            seg_d = SEG_BLANK;
            if (next_any) begin
              state_d = BLANK;
              sel_d   = next_idx;
              cnt_d   = BLANK_LD;
            end else begin
              state_d = LOAD;
              fd_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          sel_d   = '0;
          seg_d   = SEG_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      seg_q   <= SEG_BLANK;
      fd_q    <= 1'b0;
      dig_q   <= '0;
      dpm_q   <= '0;
      msk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
      dig_q   <= dig_d;
      dpm_q   <= dpm_d;
      msk_q   <= msk_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule
